// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin arbiter sharing one 2:1 data mux between two
// requesters, with a bounded hold time so a requester that never releases
// cannot starve the other.
//
// Optional build macro: MUX_ARB_STATS_EN adds saturating grant/preempt counters.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   req0, req1   level requests, held while the resource is wanted
//   in0, in1     requester data words
//   gnt0, gnt1   registered grants, never high together
//   sel          registered mux select (0 = in0, 1 = in1), holds in IDLE
//   out          registered selected data word
//   out_valid    out was captured during a grant cycle
//   busy         high while either requester is granted
//   gnt0_cnt, gnt1_cnt, preempt_cnt  (MUX_ARB_STATS_EN only) entry/preempt counts
module mux2_rr_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [15:0]      gnt0_cnt,
  output logic [15:0]      gnt1_cnt,
  output logic [15:0]      preempt_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD) + 1;
  localparam bit PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = PREEMPT_EN ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             preempt_c;
  logic             other_req_c;
  logic             last_gnt;
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_due_c;

  assign hold_due_c = PREEMPT_EN && (hold_cnt == HOLD_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; preemption only when the owner still requests
  always_comb begin
    state_nxt   = state;
    preempt_c   = 1'b0;
    other_req_c = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last_gnt ? GRANT0 : GRANT1;
        else if (req0)     state_nxt = GRANT0;
        else if (req1)     state_nxt = GRANT1;
      end
      GRANT0: begin
        other_req_c = req1;
        if (!req0) begin
          state_nxt = req1 ? GRANT1 : IDLE;
        end else if (req1 && hold_due_c) begin
          state_nxt = GRANT1;
          preempt_c = 1'b1;
        end
      end
      GRANT1: begin
        other_req_c = req0;
        if (!req1) begin
          state_nxt = req0 ? GRANT0 : IDLE;
        end else if (req0 && hold_due_c) begin
          state_nxt = GRANT0;
          preempt_c = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant-side outputs registered from next state so they track state exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      busy     <= 1'b0;
      sel      <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      gnt0 <= (state_nxt == GRANT0);
      gnt1 <= (state_nxt == GRANT1);
      busy <= (state_nxt != IDLE);
      if (state_nxt == GRANT0) begin
        sel      <= 1'b0;
        last_gnt <= 1'b0;
      end else if (state_nxt == GRANT1) begin
        sel      <= 1'b1;
        last_gnt <= 1'b1;
      end
    end
  end

  // Hold counter: counts only contended cycles, clears on any state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state_nxt != state) begin
      hold_cnt <= '0;
    end else if (other_req_c && (hold_cnt != CNT_SAT)) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  // Datapath: capture the granted word; out holds otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (state == GRANT0) begin
      out       <= in0;
      out_valid <= 1'b1;
    end else if (state == GRANT1) begin
      out       <= in1;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_ARB_STATS_EN
  // Saturating statistics counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt0_cnt    <= '0;
      gnt1_cnt    <= '0;
      preempt_cnt <= '0;
    end else begin
      if ((state != GRANT0) && (state_nxt == GRANT0) && (gnt0_cnt != 16'hFFFF))
        gnt0_cnt <= gnt0_cnt + 16'd1;
      if ((state != GRANT1) && (state_nxt == GRANT1) && (gnt1_cnt != 16'hFFFF))
        gnt1_cnt <= gnt1_cnt + 16'd1;
      if (preempt_c && (preempt_cnt != 16'hFFFF))
        preempt_cnt <= preempt_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed scenarios plus randomized traffic checked
// against an owner/wait-count reference model of the arbitration rules.
module tb_mux2_rr_arbiter;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1;
  logic [WIDTH-1:0] in0, in1;
  logic             gnt0, gnt1, sel, out_valid, busy;
  logic [WIDTH-1:0] out;
`ifdef MUX_ARB_STATS_EN
  logic [15:0]      gnt0_cnt, gnt1_cnt, preempt_cnt;
`endif

  int passed = 0;
  int total  = 0;

  // Reference model state: owner -1 = none, 0/1 = requester
  int               m_own, m_wait, m_last, m_sel, m_valid;
  int               m_g0, m_g1, m_pre;
  logic [WIDTH-1:0] m_out;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .in0(in0), .in1(in1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .out(out), .out_valid(out_valid), .busy(busy)
`ifdef MUX_ARB_STATS_EN
    , .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt), .preempt_cnt(preempt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; in0 = '0; in1 = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance the model over one clock edge using the inputs about to be sampled
  task automatic model_step();
    int nxt, mine, other;
    if (m_own >= 0) begin
      m_out   = (m_own == 1) ? in1 : in0;
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    mine  = (m_own == 1) ? int'(req1) : int'(req0);
    other = (m_own == 1) ? int'(req0) : int'(req1);
    nxt = m_own;
    if (m_own < 0) begin
      if (req0 && req1) nxt = 1 - m_last;
      else if (req0)    nxt = 0;
      else if (req1)    nxt = 1;
    end else if (mine == 0) begin
      nxt = (other != 0) ? 1 - m_own : -1;
    end else if (other != 0 && MAX_HOLD != 0 && m_wait == int'(MAX_HOLD) - 1) begin
      nxt = 1 - m_own;
      m_pre++;
    end
    if (nxt != m_own) begin
      m_wait = 0;
      if (nxt == 0) m_g0++;
      if (nxt == 1) m_g1++;
    end else if (m_own >= 0 && other != 0) begin
      m_wait++;
    end
    if (nxt >= 0) begin
      m_last = nxt;
      m_sel  = nxt;
    end
    m_own = nxt;
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; in0 = '0; in1 = '0;

    // Reset values
    do_reset();
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single request: grant after one edge, data one edge later
    req0 = 1'b1; in0 = 8'hA5;
    tick();
    check("single_gnt0", 32'(gnt0), 32'd1);
    check("single_sel", 32'(sel), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    check("single_valid_early", 32'(out_valid), 32'd0);
    tick();
    check("single_out", 32'(out), 32'hA5);
    check("single_valid", 32'(out_valid), 32'd1);

    // First tie after reset goes to 0; release hands over without IDLE
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    check("tie_gnt0", 32'(gnt0), 32'd1);
    check("tie_gnt1", 32'(gnt1), 32'd0);
    req0 = 1'b0;
    tick();
    check("handover_gnt1", 32'(gnt1), 32'd1);
    check("handover_gnt0", 32'(gnt0), 32'd0);
    check("handover_sel", 32'(sel), 32'd1);
    check("handover_busy", 32'(busy), 32'd1);

    // Continuous contention alternates every MAX_HOLD cycles
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("alt_gnt0", 32'(gnt0), ((i / 4) % 2 == 0) ? 32'd1 : 32'd0);
      check("alt_gnt1", 32'(gnt1), ((i / 4) % 2 == 1) ? 32'd1 : 32'd0);
    end
`ifdef MUX_ARB_STATS_EN
    check("alt_preempt_cnt", 32'(preempt_cnt), 32'd3);
`endif

    // Uncontended owner is never preempted
    do_reset();
    req0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_gnt0", 32'(gnt0), 32'd1);
    end

    // Asynchronous reset mid-GRANT1
    do_reset();
    req1 = 1'b1; in1 = 8'h3C;
    tick();
    tick();
    check("g1_gnt1", 32'(gnt1), 32'd1);
    check("g1_out", 32'(out), 32'h3C);
    check("g1_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_gnt1", 32'(gnt1), 32'd0);
    check("arst_sel", 32'(sel), 32'd0);
    check("arst_out", 32'(out), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
    tick();
    check("arst_tie_gnt0", 32'(gnt0), 32'd1);

`ifdef MUX_ARB_STATS_EN
    // Handovers 0 -> 1 -> 0 -> 1 from IDLE
    do_reset();
    req0 = 1'b1; tick();
    req0 = 1'b0; req1 = 1'b1; tick();
    req0 = 1'b1; req1 = 1'b0; tick();
    req0 = 1'b0; req1 = 1'b1; tick();
    check("stats_gnt1", 32'(gnt1), 32'd1);
    check("stats_gnt0_cnt", 32'(gnt0_cnt), 32'd2);
    check("stats_gnt1_cnt", 32'(gnt1_cnt), 32'd2);
    check("stats_preempt_cnt", 32'(preempt_cnt), 32'd0);
`endif

    // Randomized traffic against the reference model
    do_reset();
    m_own = -1; m_wait = 0; m_last = 1; m_sel = 0; m_valid = 0; m_out = '0;
    m_g0 = 0; m_g1 = 0; m_pre = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) req0 = ~req0;
      if ($urandom_range(7) == 0) req1 = ~req1;
      in0 = WIDTH'($urandom);
      in1 = WIDTH'($urandom);
      model_step();
      tick();
      check("rnd_gnt0", 32'(gnt0), (m_own == 0) ? 32'd1 : 32'd0);
      check("rnd_gnt1", 32'(gnt1), (m_own == 1) ? 32'd1 : 32'd0);
      check("rnd_busy", 32'(busy), (m_own >= 0) ? 32'd1 : 32'd0);
      check("rnd_sel", 32'(sel), 32'(m_sel));
      check("rnd_valid", 32'(out_valid), 32'(m_valid));
      check("rnd_out", 32'(out), 32'(m_out));
    end
`ifdef MUX_ARB_STATS_EN
    check("rnd_gnt0_cnt", 32'(gnt0_cnt), 32'(m_g0));
    check("rnd_gnt1_cnt", 32'(gnt1_cnt), 32'(m_g1));
    check("rnd_preempt_cnt", 32'(preempt_cnt), 32'(m_pre));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
Round-robin arbiter that shares one 2:1 datapath mux between two requesters.
- Owns the mux select and registers the selected data word.
- Enforces a bounded hold time so a requester that never releases cannot starve the other.
- Sits between two producer blocks and a single downstream consumer.

Parameters:
WIDTH, 8, data width of in0/in1/out.
MAX_HOLD, 16, max consecutive grant cycles while the other requester waits; 0 = unlimited (no preemption).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req0  input  1  requester 0 request; level, held while the resource is wanted.
req1  input  1  requester 1 request.
in0  input  WIDTH  requester 0 data.
in1  input  WIDTH  requester 1 data.
gnt0  output  1  grant to requester 0 (registered).
gnt1  output  1  grant to requester 1 (registered).
sel  output  1  mux select; 0 = in0, 1 = in1 (registered).
out  output  WIDTH  registered selected data.
out_valid  output  1  out holds data captured during a grant cycle.
busy  output  1  high in either GRANT state.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high (port reset).
- Reset values: state = IDLE, gnt0 = gnt1 = 0, sel = 0, out = 0, out_valid = 0, busy = 0, hold counter = 0, last_gnt = 1 (so requester 0 wins the first tie).
- States: IDLE, GRANT0, GRANT1. gnt0/gnt1/busy/sel decode directly from registered state. gnt0 and gnt1 are never high together.
- IDLE transitions:
  - req0 & req1: grant the requester opposite last_gnt.
  - Only one request: grant that requester.
  - Neither: stay in IDLE.
  - Latency: a request sampled at edge k gives a grant visible after edge k.
- GRANTx, evaluated each edge with y = other requester:
  - reqx = 0 & reqy = 1: go to GRANTy (no IDLE bubble).
  - reqx = 0 & reqy = 0: go to IDLE.
  - reqx = 1 & reqy = 1 & MAX_HOLD != 0 & hold counter == MAX_HOLD-1: preempt to GRANTy.
  - Otherwise: stay.
  - last_gnt is updated to x on every entry into GRANTx.
- Hold counter:
  - Clears on every state change.
  - Increments each cycle in a GRANT state while the other request is high.
  - Does not count while the other request is low, so an uncontended owner is never preempted.
  - Width is clog2(MAX_HOLD)+1; saturates and never wraps.
- sel:
  - 0 in GRANT0, 1 in GRANT1.
  - Holds its last value in IDLE, so the mux output does not glitch.
- Datapath:
  - On each edge where state is GRANTx: out <= inx, out_valid <= 1. Data is therefore valid one cycle after the grant cycle.
  - On any other edge: out holds, out_valid <= 0.
- Simultaneous events:
  - Release and new request in the same cycle: direct handover, per the GRANTx rules.
  - Both requests dropping while preemption is due: go to IDLE.
- Reset mid-grant: all outputs return to reset values immediately (asynchronously). The first tie after reset goes to requester 0.

Optional Feature:
MUX_ARB_STATS_EN
- Defined:
  - Adds output ports gnt0_cnt [15:0] and gnt1_cnt [15:0].
  - Each counts entries into GRANT0/GRANT1 respectively, saturates at 16'hFFFF, and resets to 0.
  - Also adds output preempt_cnt [15:0], counting preemptions, saturating.
- Undefined: these ports and their counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then req0 = 1 only, in0 = 8'hA5 -> gnt0 = 1 one edge later; out = 8'hA5 with out_valid = 1 one edge after that; sel = 0.
- req0 = req1 = 1 asserted together from IDLE after reset -> gnt0 first. Drop req0 -> next edge gnt1 = 1, sel = 1, no IDLE cycle.
- MAX_HOLD = 4, req0 and req1 both held high continuously -> grants alternate 4 cycles gnt0, 4 cycles gnt1, repeating; never both high.
- MAX_HOLD = 4, req0 held for 20 cycles with req1 = 0 -> gnt0 stays high for all 20 cycles; no preemption.
- Assert reset asynchronously mid-GRANT1 -> gnt1, sel, out, out_valid drop to 0 before the next clk edge. Then tie -> gnt0 wins.
- With MUX_ARB_STATS_EN: 3 handovers 0->1->0->1 from IDLE -> gnt0_cnt = 2, gnt1_cnt = 2, preempt_cnt matches the number of forced switches.
